// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-operand and response bundle between alu_cmd_issuer and its environment.
// Macro ACC_CHAIN_EN adds the cmd_use_acc signal.
interface alu_cmd_issuer_if #(
   parameter int unsigned N = 8
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_opcode;
   logic [N-1:0] cmd_opa;
   logic [N-1:0] cmd_opb;
`ifdef ACC_CHAIN_EN
   logic         cmd_use_acc;
`endif
   logic [N-1:0] alu_opa;
   logic [N-1:0] alu_opb;
   logic [2:0]   alu_opcode;
   logic [N-1:0] alu_out;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_data;
   logic         rsp_zero;
   logic         rsp_err;

`ifdef ACC_CHAIN_EN
   modport master (
      input  cmd_valid, cmd_opcode, cmd_opa, cmd_opb, cmd_use_acc, alu_out, rsp_ready,
      output cmd_ready, alu_opa, alu_opb, alu_opcode, rsp_valid, rsp_data, rsp_zero, rsp_err
   );
   modport slave (
      output cmd_valid, cmd_opcode, cmd_opa, cmd_opb, cmd_use_acc, alu_out, rsp_ready,
      input  cmd_ready, alu_opa, alu_opb, alu_opcode, rsp_valid, rsp_data, rsp_zero, rsp_err
   );
`else
   modport master (
      input  cmd_valid, cmd_opcode, cmd_opa, cmd_opb, alu_out, rsp_ready,
      output cmd_ready, alu_opa, alu_opb, alu_opcode, rsp_valid, rsp_data, rsp_zero, rsp_err
   );
   modport slave (
      output cmd_valid, cmd_opcode, cmd_opa, cmd_opb, alu_out, rsp_ready,
      input  cmd_ready, alu_opa, alu_opb, alu_opcode, rsp_valid, rsp_data, rsp_zero, rsp_err
   );
`endif
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a combinational ALU and returns its result on a response channel.
// Optional feature macro: ACC_CHAIN_EN (operand A may come from the last good result).
module alu_cmd_issuer #(
   parameter int unsigned N = 8
) (
   input logic             clk,
   input logic             rst,
   alu_cmd_issuer_if.master bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e       state_q, state_d;
   logic         cmd_ready_q, cmd_ready_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [N-1:0] alu_opa_q, alu_opa_d;
   logic [N-1:0] alu_opb_q, alu_opb_d;
   logic [2:0]   alu_opcode_q, alu_opcode_d;
   logic [N-1:0] rsp_data_q, rsp_data_d;
   logic         rsp_zero_q, rsp_zero_d;
   logic         rsp_err_q, rsp_err_d;
   logic [N-1:0] opa_src;
   logic         op_legal;

`ifdef ACC_CHAIN_EN
   logic [N-1:0] acc_q, acc_d;
   assign opa_src = bus.cmd_use_acc ? acc_q : bus.cmd_opa;
`else
   assign opa_src = bus.cmd_opa;
`endif

   assign op_legal = (bus.cmd_opcode <= 3'd4);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         alu_opa_q    <= '0;
         alu_opb_q    <= '0;
         alu_opcode_q <= '0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         alu_opa_q    <= alu_opa_d;
         alu_opb_q    <= alu_opb_d;
         alu_opcode_q <= alu_opcode_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

`ifdef ACC_CHAIN_EN
   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end
`endif

   always_comb begin
      state_d      = state_q;
      alu_opa_d    = alu_opa_q;
      alu_opb_d    = alu_opb_q;
      alu_opcode_d = alu_opcode_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
`ifdef ACC_CHAIN_EN
      acc_d        = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               if (op_legal) begin
                  alu_opa_d    = opa_src;
                  alu_opb_d    = bus.cmd_opb;
                  alu_opcode_d = bus.cmd_opcode;
                  state_d      = EXEC;
               end else begin
                  rsp_data_d = '0;
                  rsp_zero_d = 1'b0;
                  rsp_err_d  = 1'b1;
                  state_d    = RESP;
               end
            end
         end
         EXEC: begin
            rsp_data_d = bus.alu_out;
            rsp_zero_d = (bus.alu_out == '0);
            rsp_err_d  = 1'b0;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               state_d = IDLE;
`ifdef ACC_CHAIN_EN
               if (!rsp_err_q) acc_d = rsp_data_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs are registered copies of the next-state decode.
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.alu_opa    = alu_opa_q;
   assign bus.alu_opb    = alu_opb_q;
   assign bus.alu_opcode = alu_opcode_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed cases followed by random commands against a reference model.
module tb_alu_cmd_issuer;
   localparam int unsigned N = 8;
   localparam int MASK = (1 << N) - 1;
`ifdef ACC_CHAIN_EN
   localparam bit HAS_ACC = 1'b1;
`else
   localparam bit HAS_ACC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_cmd_issuer_if #(.N(N)) bus ();
   alu_cmd_issuer #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   // Combinational ALU the issuer drives.
   always_comb begin
      case (bus.alu_opcode)
         3'd0:    bus.alu_out = bus.alu_opa + bus.alu_opb;
         3'd1:    bus.alu_out = bus.alu_opa - bus.alu_opb;
         3'd2:    bus.alu_out = bus.alu_opa & bus.alu_opb;
         3'd3:    bus.alu_out = bus.alu_opa | bus.alu_opb;
         3'd4:    bus.alu_out = ~bus.alu_opa;
         default: bus.alu_out = '0;
      endcase
   end

   int checks = 0;
   int failures = 0;
   int acc_m = 0;
   int exp_opa = 0, exp_opb = 0, exp_op = 0;
   int pend_res = 0;
   bit pend_err = 1'b0;

   function automatic int ref_result(int op, int a, int b);
      case (op)
         0:       return (a + b) & MASK;
         1:       return (a - b) & MASK;
         2:       return a & b;
         3:       return a | b;
         4:       return (~a) & MASK;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_alu(input string tag);
      chk({tag, "_alu_opa"}, 32'(bus.alu_opa), exp_opa);
      chk({tag, "_alu_opb"}, 32'(bus.alu_opb), exp_opb);
      chk({tag, "_alu_opcode"}, 32'(bus.alu_opcode), exp_op);
   endtask

   task automatic drive_cmd(input int op, input int a, input int b, input bit ua);
      bus.cmd_opcode = 3'(op);
      bus.cmd_opa    = N'(a);
      bus.cmd_opb    = N'(b);
`ifdef ACC_CHAIN_EN
      bus.cmd_use_acc = ua;
`endif
      bus.cmd_valid  = 1'b1;
   endtask

   // Starts and ends just after a falling edge.
   task automatic accept(input int op, input int a, input int b, input bit ua);
      int n;
      int eff_a;
      n = 0;
      drive_cmd(op, a, b, ua);
      while (bus.cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         chk("accept_timeout", 32'(bus.cmd_ready), 1);
         $fatal(1, "FAIL accept_timeout observed=%0d cycles expected=<20", n);
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      eff_a = (HAS_ACC && ua) ? acc_m : a;
      if (op <= 4) begin
         exp_opa  = eff_a;
         exp_opb  = b;
         exp_op   = op;
         pend_res = ref_result(op, eff_a, b);
         pend_err = 1'b0;
         chk("exec_rsp_valid", 32'(bus.rsp_valid), 0);
         chk("exec_cmd_ready", 32'(bus.cmd_ready), 0);
         chk_alu("exec");
      end else begin
         pend_res = 0;
         pend_err = 1'b1;
         chk("illegal_rsp_valid", 32'(bus.rsp_valid), 1);
         chk_alu("illegal");
      end
   endtask

   task automatic respond(input int wait_n, input bit pend_en, input int p_op, input int p_a, input int p_b);
      if (!pend_err) @(negedge clk);
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("rsp_data", 32'(bus.rsp_data), pend_res);
      chk("rsp_zero", 32'(bus.rsp_zero), (pend_res == 0 && !pend_err) ? 1 : 0);
      chk("rsp_err", 32'(bus.rsp_err), 32'(pend_err));
      if (pend_en) drive_cmd(p_op, p_a, p_b, 1'b0);
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.rsp_valid), 1);
         chk("hold_data", 32'(bus.rsp_data), pend_res);
         chk("hold_err", 32'(bus.rsp_err), 32'(pend_err));
         chk("hold_cmd_ready", 32'(bus.cmd_ready), 0);
         chk("hold_alu_opcode", 32'(bus.alu_opcode), exp_op);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("post_hs_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("post_hs_cmd_ready", 32'(bus.cmd_ready), 1);
      if (!pend_err) acc_m = pend_res;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
      chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
      chk({tag, "_rsp_zero"}, 32'(bus.rsp_zero), 0);
      chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
      chk_alu(tag);
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_opcode = '0;
      bus.cmd_opa    = '0;
      bus.cmd_opb    = '0;
`ifdef ACC_CHAIN_EN
      bus.cmd_use_acc = 1'b0;
`endif
      bus.rsp_ready  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // Basic add, then wrap-around cases
      accept(0, 8'h12, 8'h34, 1'b0); respond(0, 1'b0, 0, 0, 0);
      accept(1, 8'h00, 8'h01, 1'b0); respond(0, 1'b0, 0, 0, 0);
      accept(0, 8'hFF, 8'h01, 1'b0); respond(0, 1'b0, 0, 0, 0);

      // Illegal opcode: one-cycle latency, alu_* untouched
      accept(6, 8'hAA, 8'h55, 1'b0); respond(1, 1'b0, 0, 0, 0);

      // Backpressure with a second command waiting
      accept(2, 8'hF0, 8'h3C, 1'b0); respond(5, 1'b1, 0, 8'h11, 8'h22);
      accept(0, 8'h11, 8'h22, 1'b0); respond(0, 1'b0, 0, 0, 0);

      // Reset during EXEC drops the response
      accept(3, 8'h0F, 8'hF0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_opa = 0; exp_opb = 0; exp_op = 0; acc_m = 0;
      chk_reset_vals("midexec_reset");
      @(negedge clk);
      chk("after_reset_no_rsp", 32'(bus.rsp_valid), 0);
      accept(0, 8'h01, 8'h01, 1'b0); respond(0, 1'b0, 0, 0, 0);

`ifdef ACC_CHAIN_EN
      accept(0, 8'h05, 8'h03, 1'b0); respond(0, 1'b0, 0, 0, 0);
      accept(1, 8'hEE, 8'h02, 1'b1); respond(0, 1'b0, 0, 0, 0);
      accept(7, 8'h33, 8'h44, 1'b1); respond(0, 1'b0, 0, 0, 0);
      accept(0, 8'h99, 8'h00, 1'b1); respond(0, 1'b0, 0, 0, 0);
      chk("acc_chain_result", 32'(bus.rsp_data), 8'h06);
`endif

      for (int i = 0; i < 40; i++) begin
         int op, a, b, w;
         bit ua;
         op = int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, MASK));
         b  = int'($urandom_range(0, MASK));
         ua = 1'($urandom_range(0, 1));
         w  = int'($urandom_range(0, 3));
         accept(op, a, b, ua);
         respond(w, 1'b0, 0, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
